// File: rtl/seg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl_pkg
// Description : Shared FSM encodings and active-low 7-segment glyph constants
//               for the distance readout display path.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_ctrl_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Active-low glyphs, bit order g..a (seg[6]=g, seg[0]=a)
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational BCD nibble to active-low 7-segment decoder.
//               Codes 10-15 produce a blank digit.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Glyph lookup; non-decimal codes blank the digit
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Binary-to-BCD conversion (sequential double-dabble, one bit
//               per clock) with atomic commit, plus a multiplexed 7-segment
//               scanner sharing a single decoder.
//               Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int BIN_W    = 12,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  // One spare nibble above the displayed digits catches overflow
  localparam int SCR_W = 4 * (DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t                   state, state_nxt;
  logic [BIN_W-1:0]         shreg;
  logic [SCR_W-1:0]         scratch, scratch_adj;
  logic [SCR_W+BIN_W-1:0]   shift_word;
  logic [CNT_W-1:0]         cnt;
  logic                     top_nz;

  logic [PRE_W-1:0]         presc;
  logic [IDX_W-1:0]         idx, idx_nxt;
  logic                     tick;
  logic [3:0]               scan_digit;
  logic [6:0]               seg_dec;

  assign top_nz     = (scratch[SCR_W-1 -: 4] != 4'd0);
  assign shift_word = {scratch_adj, shreg} << 1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: SHIFT lasts exactly BIN_W cycles, COMMIT one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Double-dabble correction: add 3 to every nibble >= 5 before shifting
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath; visible results update only at COMMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      bcd_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shreg   <= bin_in;
            scratch <= '0;
            cnt     <= CNT_W'(BIN_W);
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          scratch <= shift_word[SCR_W+BIN_W-1:BIN_W];
          shreg   <= shift_word[BIN_W-1:0];
          cnt     <= cnt - 1'b1;
        end
        COMMIT: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (top_nz) begin
            ovf     <= 1'b1;
            bcd_out <= {DIGITS{4'h9}};
          end else begin
            ovf     <= 1'b0;
            bcd_out <= scratch[4*DIGITS-1:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_mask, mask_nxt;

  // Mark digits above the highest nonzero one; digit 0 always shown
  always_comb begin
    logic seen;
    seen     = 1'b0;
    mask_nxt = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      seen        = seen | (scratch[4*i +: 4] != 4'd0);
      mask_nxt[i] = ~seen;
    end
  end

  // Mask is committed together with the digits; overflow shows all nines
  always_ff @(posedge clk) begin
    if (rst)                  blank_mask <= '0;
    else if (state == COMMIT) blank_mask <= top_nz ? '0 : mask_nxt;
  end
`endif

  assign tick       = (presc == PRE_W'(SCAN_DIV - 1));
  assign idx_nxt    = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
  assign scan_digit = bcd_out[4*idx_nxt +: 4];

  seg7_decode u_dec (
    .digit (scan_digit),
    .seg   (seg_dec)
  );

  // Free-running scanner: advance one digit slot per prescaler wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= IDX_W'(DIGITS - 1);
      an    <= '1;
      seg   <= SEG_BLANK;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        idx <= idx_nxt;
        an  <= ~(DIGITS'(1) << idx_nxt);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        seg <= blank_mask[idx_nxt] ? SEG_BLANK : seg_dec;
`else
        seg <= seg_dec;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Sequencer for the shared 7-segment display path of the distance readout.
- Accepts a binary measurement with a load pulse and converts it to packed BCD by sequential double-dabble, one bit per clock.
- Commits the BCD digits atomically and time-multiplexes them onto one shared segment decoder with active-low digit enables.
- Sits between the echo-width/distance calculator and the board's segment/anode pins.

Parameters:
- BIN_W, 12: width of the binary input.
- DIGITS, 4: number of display digits / BCD nibbles.
- SCAN_DIV, 50000: clock cycles per digit slot; simulation uses 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  start-conversion strobe; sampled only in IDLE.
- bin_in  input  BIN_W  binary value; captured on the accepted load.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; new bcd_out/ovf valid.
- ovf  output  1  last committed value exceeded 10^DIGITS-1.
- bcd_out  output  4*DIGITS  committed BCD, digit 0 in bits [3:0].
- seg  output  7  active-low segments, seg[0]=a .. seg[6]=g.
- an  output  DIGITS  active-low digit enables, one-hot-low.

Behaviour:
- Reset values: busy=0, done=0, ovf=0, bcd_out=0, seg=7'b1111111, an=all ones, scan index=DIGITS-1, prescaler=0, FSM=IDLE.
- FSM has three states: IDLE, SHIFT, COMMIT.
- IDLE: when load=1 at an edge, capture bin_in into the shift register and clear a scratch of DIGITS+1 nibbles. Set cnt=BIN_W and busy=1, then go to SHIFT.
- SHIFT: each cycle, add 3 to every scratch nibble >=5, then shift {scratch,shreg} left by 1 and decrement cnt. When cnt reaches 0, go to COMMIT. This state occupies exactly BIN_W cycles.
- COMMIT (one cycle):
  - If the top scratch nibble is nonzero, set ovf=1 and bcd_out=all nibbles 9.
  - Otherwise set ovf=0 and bcd_out=low DIGITS nibbles.
  - Assert done=1 for this cycle only, clear busy, return to IDLE.
- Latency: load accepted at edge k → done high in the cycle after edge k+BIN_W+1. busy is high for exactly BIN_W+1 cycles.
- load while busy=1, including during COMMIT, is ignored. It is not queued.
- bcd_out changes only at COMMIT, so the display never shows a partial conversion.
- Scan prescaler counts 0..SCAN_DIV-1 and produces a tick at the terminal count, then wraps to 0.
- On tick:
  - idx <= (idx==DIGITS-1) ? 0 : idx+1.
  - an <= ~(1<<new idx).
  - seg <= decode(bcd_out nibble[new idx]), registered.
- The first tick after reset therefore shows digit 0. Scanning runs continuously, independent of the FSM.
- Decode table, active-low, bits g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10–15 = 1111111 (blank)
- Reset mid-conversion: return to IDLE immediately, no done pulse, bcd_out cleared.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: at COMMIT, a blank mask register records every digit above the highest nonzero digit. On scan, masked digits drive seg=1111111 while an still cycles. Digit 0 is never blanked; when ovf=1 the mask is cleared.
- Undefined: no mask register; all digits are always decoded.

Decomposition:
- Shared package/include holds:
  - FSM state encodings (IDLE, SHIFT, COMMIT).
  - SEG_BLANK=7'b1111111.
  - Digit segment constants SEG_0..SEG_9.
- One natural sub-module, seg7_decode: purely combinational, 4-bit in to 7-bit active-low out, 10–15 blank. Instantiated once and shared by the scanner.

Test Plan:
- Reset then idle with SCAN_DIV=4 → an sequence 1110,1101,1011,0111 repeating every 16 cycles; seg=1000000 throughout; busy=done=0.
- load with bin_in=12'd1234 → busy for 13 cycles, done pulse 13 cycles after load edge, bcd_out=16'h1234, ovf=0; digit 2 slot shows seg=0100100.
- load with 12'd4095, DIGITS=4 → bcd_out=16'h4095. Rerun with DIGITS=3 and 12'd1000 → ovf=1, bcd_out=12'h999.
- Second load pulsed 5 cycles into a conversion → ignored; exactly one done, with the first value's BCD.
- rst asserted 6 cycles into a conversion of 12'd777 → no done, bcd_out=0, FSM accepts a new load the cycle after rst deasserts.
- With SEG_LEADING_ZERO_BLANK_EN and bin_in=12'd7 → digits 3..1 show 1111111, digit 0 shows 1111000. Without the macro → digits 3..1 show 1000000.
